// File: rtl/can_pkg.sv
// Shared CAN CRC-15 constants and the CRC engine state type.
package can_pkg;

    localparam int          CAN_CRC_WIDTH = 15;
    localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE,
        CHECK
    } crc_state_e;

endpackage

// File: rtl/can_crc15_step.sv
// Combinational single-bit CAN CRC LFSR step (x^15 term implicit in POLY).
import can_pkg::*;

module can_crc15_step #(
    parameter int           W    = CAN_CRC_WIDTH,
    parameter logic [W-1:0] POLY = CAN_CRC_POLY
) (
    input  logic [W-1:0] crc_i,
    input  logic         bit_i,
    output logic [W-1:0] crc_o
);

    logic nxt;

    assign nxt   = bit_i ^ crc_i[W-1];
    assign crc_o = {crc_i[W-2:0], 1'b0} ^ (nxt ? POLY : '0);

endmodule

// File: rtl/can_crc15_calc.sv
// CAN CRC-15 accumulator: start/step/stop FSM with saturating bit counter.
// Optional received-CRC comparison is built when CAN_CRC_CHECK_EN is defined.
import can_pkg::*;

module can_crc15_calc #(
    parameter int                   CRC_WIDTH = CAN_CRC_WIDTH,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CAN_CRC_POLY,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT  = '0,
    parameter int                   CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_crc,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 crc_end,
    output logic [CRC_WIDTH-1:0] crc_out,
    output logic                 crc_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] bit_count
`ifdef CAN_CRC_CHECK_EN
    ,
    input  logic                 rx_crc_valid,
    input  logic                 rx_crc_bit,
    output logic                 crc_chk_done,
    output logic                 crc_err
`endif
);

    crc_state_e           state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CRC_WIDTH-1:0] step_in, step_out;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) return c;
        return c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // A start pulse coinciding with a bit steps from CRC_INIT so the SOF bit is kept.
    assign step_in = enable_crc ? CRC_INIT : crc_q;

    can_crc15_step #(
        .W    (CRC_WIDTH),
        .POLY (CRC_POLY)
    ) u_step (
        .crc_i (step_in),
        .bit_i (bit_in),
        .crc_o (step_out)
    );

`ifdef CAN_CRC_CHECK_EN
    logic [3:0] idx_q, idx_d;
    logic       mis_q, mis_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       seen_q, seen_d;
    logic       mis_now;

    assign mis_now = mis_q | (rx_crc_bit != crc_q[4'(CRC_WIDTH-1) - idx_q]);
`endif

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
`ifdef CAN_CRC_CHECK_EN
        idx_d   = idx_q;
        mis_d   = mis_q;
        err_d   = err_q;
        done_d  = 1'b0;
        seen_d  = seen_q;
`endif
        if (enable_crc) begin
            state_d = CALC;
            crc_d   = bit_valid ? step_out : CRC_INIT;
            cnt_d   = bit_valid ? CNT_WIDTH'(1) : '0;
`ifdef CAN_CRC_CHECK_EN
            idx_d   = '0;
            mis_d   = 1'b0;
            err_d   = 1'b0;
            seen_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                CALC: begin
                    if (bit_valid) begin
                        crc_d = step_out;
                        cnt_d = sat_inc(cnt_q);
                    end
                    if (crc_end) state_d = DONE;
                end
`ifdef CAN_CRC_CHECK_EN
                DONE, CHECK: begin
                    // Once a full CRC field has been compared, further bits wait for a restart.
                    if (rx_crc_valid && (state_q == CHECK || !seen_q)) begin
                        if (idx_q == 4'(CRC_WIDTH-1)) begin
                            state_d = DONE;
                            err_d   = mis_now;
                            done_d  = 1'b1;
                            seen_d  = 1'b1;
                            idx_d   = '0;
                            mis_d   = 1'b0;
                        end else begin
                            state_d = CHECK;
                            idx_d   = idx_q + 4'd1;
                            mis_d   = mis_now;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
`ifdef CAN_CRC_CHECK_EN
            idx_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            seen_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
`ifdef CAN_CRC_CHECK_EN
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            done_q  <= done_d;
            seen_q  <= seen_d;
`endif
        end
    end

    assign crc_out   = crc_q;
    assign bit_count = cnt_q;
    assign busy      = (state_q == CALC);
    assign crc_ready = (state_q == DONE) || (state_q == CHECK);
`ifdef CAN_CRC_CHECK_EN
    assign crc_chk_done = done_q;
    assign crc_err      = err_q;
`endif

endmodule

// File: tb/tb_can_crc15_calc.sv
// Randomized scoreboard bench for can_crc15_calc; CRC expectations come from GF(2) long division.
module tb_can_crc15_calc;

    logic        clk = 1'b0;
    logic        rst, enable_crc, bit_valid, bit_in, crc_end;
    logic [14:0] crc_out;
    logic        crc_ready, busy;
    logic [6:0]  bit_count;
`ifdef CAN_CRC_CHECK_EN
    logic        rx_crc_valid, rx_crc_bit, crc_chk_done, crc_err;
`endif

    can_crc15_calc dut (
        .clk        (clk),
        .rst        (rst),
        .enable_crc (enable_crc),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .crc_end    (crc_end),
        .crc_out    (crc_out),
        .crc_ready  (crc_ready),
        .busy       (busy),
        .bit_count  (bit_count)
`ifdef CAN_CRC_CHECK_EN
        ,
        .rx_crc_valid (rx_crc_valid),
        .rx_crc_bit   (rx_crc_bit),
        .crc_chk_done (crc_chk_done),
        .crc_err      (crc_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [14:0] crc;
        logic [6:0]  cnt;
    } exp_t;

    exp_t expq[$];
    bit   errq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Remainder of msg(x) * x^15 divided by x^15 + 0x4599, by explicit long division.
    function automatic logic [14:0] ref_crc(input bit msg[$]);
        bit          a[$];
        logic [15:0] g;
        logic [14:0] r;
        g = 16'hC599;
        a = msg;
        repeat (15) a.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (a[i])
                for (int j = 0; j < 16; j++) a[i+j] = a[i+j] ^ g[15-j];
        for (int k = 0; k < 15; k++) r[14-k] = a[msg.size()+k];
        return r;
    endfunction

    function automatic logic [6:0] sat_cnt(input int n);
        return (n > 127) ? 7'd127 : 7'(n);
    endfunction

    task automatic drive(input bit en, input bit bv, input bit bi, input bit ce);
        enable_crc = en;
        bit_valid  = bv;
        bit_in     = bi;
        crc_end    = ce;
        @(posedge clk);
        #1;
        enable_crc = 1'b0;
        bit_valid  = 1'b0;
        crc_end    = 1'b0;
    endtask

    task automatic run_frame(input bit msg[$], input bit sof_on_start, input bit end_with_last,
                             input bit start_with_end, input int gaps, output logic [14:0] exp_crc);
        int   k;
        bit   ended;
        exp_t e;
        k     = 0;
        ended = 1'b0;
        if (sof_on_start) begin
            drive(1'b1, 1'b1, msg[0], start_with_end);
            k = 1;
        end else begin
            drive(1'b1, 1'b0, 1'($urandom), start_with_end);
        end
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(crc_ready), 32'd0);
        while (k < msg.size()) begin
            repeat ($urandom_range(0, gaps)) drive(1'b0, 1'b0, 1'($urandom), 1'b0);
            ended = end_with_last && (k == msg.size() - 1);
            drive(1'b0, 1'b1, msg[k], ended);
            k++;
        end
        if (!ended) begin
            repeat ($urandom_range(0, gaps)) drive(1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        e.crc = ref_crc(msg);
        e.cnt = sat_cnt(msg.size());
        expq.push_back(e);
        exp_crc = e.crc;
        chk("end_ready", 32'(crc_ready), 32'd1);
        repeat (3) drive(1'b0, 1'b1, 1'($urandom), 1'b0);
        chk("done_frozen", 32'(crc_out), 32'(e.crc));
        chk("done_cnt", 32'(bit_count), 32'(e.cnt));
        chk("done_ready", 32'(crc_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

`ifdef CAN_CRC_CHECK_EN
    task automatic rx_field(input logic [14:0] val, input int flip);
        bit b;
        for (int i = 0; i < 15; i++) begin
            b = val[14-i];
            if (i == flip) b = ~b;
            rx_crc_valid = 1'b1;
            rx_crc_bit   = b;
            @(posedge clk);
            #1;
            rx_crc_valid = 1'b0;
        end
        errq.push_back(flip >= 0);
    endtask
`endif

    // Scoreboard monitor: one expected entry per DONE entry, one per check-done pulse.
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (crc_ready === 1'b1 && rdy_prev !== 1'b1) begin
            if (expq.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
            else begin
                e = expq.pop_front();
                chk("frame_crc", 32'(crc_out), 32'(e.crc));
                chk("frame_cnt", 32'(bit_count), 32'(e.cnt));
            end
        end
        rdy_prev <= crc_ready;
`ifdef CAN_CRC_CHECK_EN
        if (crc_chk_done === 1'b1) begin
            if (errq.size() == 0) chk("unexpected_chk_done", 32'd1, 32'd0);
            else chk("chk_err", 32'(crc_err), 32'(errq.pop_front()));
        end
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          msg[$];
        logic [14:0] c;
        int          n;
        rst = 1'b1;
        enable_crc = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        crc_end    = 1'b0;
`ifdef CAN_CRC_CHECK_EN
        rx_crc_valid = 1'b0;
        rx_crc_bit   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_crc", 32'(crc_out), 32'd0);
        chk("rst_cnt", 32'(bit_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(crc_ready), 32'd0);
        rst = 1'b0;

        // crc_end and bit_valid in IDLE are ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(crc_ready), 32'd0);
        chk("idle_cnt", 32'(bit_count), 32'd0);
        chk("idle_crc", 32'(crc_out), 32'd0);

        msg = '{1'b1, 1'b0};
        run_frame(msg, 1'b0, 1'b0, 1'b0, 0, c);
        chk("t1_crc", 32'(crc_out), 32'h4EAB);
        chk("t1_cnt", 32'(bit_count), 32'd2);

`ifdef CAN_CRC_CHECK_EN
        rx_field(15'h4EAB, -1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_err_ok", 32'(crc_err), 32'd0);
        rx_crc_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_crc_valid = 1'b0;
        chk("t5_extra_ready", 32'(crc_ready), 32'd1);
        run_frame(msg, 1'b0, 1'b1, 1'b0, 0, c);
        rx_field(15'h4EAB, 11);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_err_bad", 32'(crc_err), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_err_cleared", 32'(crc_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expq.push_back('{crc: 15'h0000, cnt: 7'd0});
`endif

        msg = '{8{1'b0}};
        run_frame(msg, 1'b0, 1'b1, 1'b0, 1, c);
        chk("t2_crc", 32'(crc_out), 32'h0000);
        chk("t2_cnt", 32'(bit_count), 32'd8);

        msg = '{1'b1};
        run_frame(msg, 1'b1, 1'b0, 1'b0, 0, c);
        chk("t3_crc", 32'(crc_out), 32'h4599);
        chk("t3_cnt", 32'(bit_count), 32'd1);

        // reset mid-frame aborts to IDLE
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 1'($urandom), 1'b0);
        chk("t4_pre_cnt", 32'(bit_count), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_crc", 32'(crc_out), 32'd0);
        chk("t4_cnt", 32'(bit_count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ready", 32'(crc_ready), 32'd0);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_ign_cnt", 32'(bit_count), 32'd0);
        chk("t4_ign_crc", 32'(crc_out), 32'd0);

        msg.delete();
        repeat (200) msg.push_back(1'($urandom));
        run_frame(msg, 1'b1, 1'b1, 1'b0, 0, c);
        chk("t6_cnt_sat", 32'(bit_count), 32'd127);

        for (int f = 0; f < 15; f++) begin
            msg.delete();
            n = $urandom_range(1, 100);
            repeat (n) msg.push_back(1'($urandom));
            run_frame(msg, 1'($urandom), 1'($urandom), 1'($urandom), 3, c);
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("errq_drained", 32'(errq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
